sst_reg_engine: RTL and testbench

- Initiator side of the mapper save-state register bus (sst_act, sst_addr, sst_we_reg, sst_dato, sst_di).
- On command, walks mapper register addresses 0..REG_COUNT-1:
  - SAVE reads each register back and stores it into an external snapshot buffer RAM.
  - RESTORE reads the buffer and writes each byte into the mapper.
- Sits between the menu/OS command interface and the active mapper.

---
 rtl/sst_reg_engine.sv | 137 +++++++++++++
 tb/tb_sst_reg_engine.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sst_reg_engine.sv
// sst_reg_engine: save-state bus initiator.
// Walks mapper registers, saving to or restoring from a snapshot RAM.
module sst_reg_engine #(
  parameter int REG_COUNT = 128,
  parameter int HOLD      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_start,
  input  logic       cmd_save,
  output logic       busy,
  output logic       done,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [7:0] buf_addr,
  output logic       buf_we,
  output logic [7:0] buf_do,
  input  logic [7:0] buf_di
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [8:0] LAST = 9'(REG_COUNT - 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  typedef enum logic [3:0] {
    IDLE,
    SETUP,
    SV_WAIT,
    SV_STORE,
    RS_FETCH,
    RS_WRITE,
    RS_RELEASE,
    NEXT,
    FINISH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          save_q;
  logic [8:0]    idx;
  logic [CW-1:0] cnt;
  logic          hold_end;

  assign hold_end = (cnt == '0);

  // idx is stable from SETUP through NEXT, so the RAM sees the
  // address a full cycle before RS_FETCH consumes its data.
  assign sst_addr = idx[7:0];
  assign buf_addr = idx[7:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    sst_act = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy    = 1'b0;
        sst_act = 1'b0;
        if (cmd_start) state_d = SETUP;
      end
      SETUP:      state_d = save_q ? SV_WAIT : RS_FETCH;
      SV_WAIT:    if (hold_end) state_d = SV_STORE;
      SV_STORE:   state_d = NEXT;
      RS_FETCH:   state_d = RS_WRITE;
      RS_WRITE:   if (hold_end) state_d = RS_RELEASE;
      RS_RELEASE: state_d = NEXT;
      NEXT:       state_d = (idx == LAST) ? FINISH : SETUP;
      FINISH: begin
        busy    = 1'b0;
        sst_act = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        sst_act = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: index, hold counter, strobes and data latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      save_q     <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      sst_we_reg <= 1'b0;
      sst_dato   <= '0;
      buf_we     <= 1'b0;
      buf_do     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_start) begin
            save_q <= cmd_save;
            idx    <= '0;
          end
        end
        SETUP: cnt <= RELOAD;
        SV_WAIT: begin
          if (hold_end) begin
            buf_we <= 1'b1;
            buf_do <= sst_di;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SV_STORE: buf_we <= 1'b0;
        RS_FETCH: begin
          sst_dato   <= buf_di;
          sst_we_reg <= 1'b1;
          cnt        <= RELOAD;
        end
        RS_WRITE: begin
          if (hold_end) sst_we_reg <= 1'b0;
          else          cnt <= cnt - CW'(1);
        end
        NEXT: if (idx != LAST) idx <= idx + 9'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sst_reg_engine.sv
// tb_sst_reg_engine: directed scoreboard bench for sst_reg_engine.
// Two instances: 128 regs / HOLD 4, and 256 regs / HOLD 2.
module tb_sst_reg_engine;

  logic clk;
  logic rst;
  logic cmd_save;
  logic start0, start1;

  logic       busy0, done0, act0, we0, bwe0;
  logic [7:0] addr0, dato0, di0, baddr0, bdo0, bdi0;
  logic       busy1, done1, act1, we1, bwe1;
  logic [7:0] addr1, dato1, di1, baddr1, bdo1, bdi1;

  logic [7:0] mem0 [256];
  logic [7:0] mreg0 [256];
  logic       preload;

  int total = 0;
  int bad   = 0;

  bit sel;
  logic       m_busy, m_done, m_act, m_we, m_bwe;
  logic [7:0] m_addr, m_dato, m_baddr, m_bdo;

  logic [15:0] exp_q [$];

  int busy_n, done_n, err_we, err_bwe, err_act;
  int err_addr, err_hold, err_len, err_extra;

  sst_reg_engine #(.REG_COUNT(128), .HOLD(4)) u0 (
    .clk(clk), .rst(rst),
    .cmd_start(start0), .cmd_save(cmd_save),
    .busy(busy0), .done(done0),
    .sst_act(act0), .sst_addr(addr0),
    .sst_we_reg(we0), .sst_dato(dato0), .sst_di(di0),
    .buf_addr(baddr0), .buf_we(bwe0),
    .buf_do(bdo0), .buf_di(bdi0)
  );

  sst_reg_engine #(.REG_COUNT(256), .HOLD(2)) u1 (
    .clk(clk), .rst(rst),
    .cmd_start(start1), .cmd_save(cmd_save),
    .busy(busy1), .done(done1),
    .sst_act(act1), .sst_addr(addr1),
    .sst_we_reg(we1), .sst_dato(dato1), .sst_di(di1),
    .buf_addr(baddr1), .buf_we(bwe1),
    .buf_do(bdo1), .buf_di(bdi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mapper read model and snapshot RAM models
  assign di0  = addr0 ^ 8'h5A;
  assign di1  = addr1 ^ 8'h5A;
  assign bdi1 = 8'h00;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= ~(i[7:0]);
      end
    end else if (bwe0) begin
      mem0[baddr0] <= bdo0;
    end
    bdi0 <= mem0[baddr0];
  end

  always @(posedge clk) begin
    if (we0) mreg0[addr0] <= dato0;
  end

  always_comb begin
    m_busy  = sel ? busy1  : busy0;
    m_done  = sel ? done1  : done0;
    m_act   = sel ? act1   : act0;
    m_we    = sel ? we1    : we0;
    m_bwe   = sel ? bwe1   : bwe0;
    m_addr  = sel ? addr1  : addr0;
    m_dato  = sel ? dato1  : dato0;
    m_baddr = sel ? baddr1 : baddr0;
    m_bdo   = sel ? bdo1   : bdo0;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ops(input bit save, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = i[7:0];
      if (save) exp_q.push_back({a, a ^ 8'h5A});
      else      exp_q.push_back({a, ~a});
    end
  endtask

  task automatic run_op(input bit save, input int maxaddr,
                        input int hold, input int inject_at);
    int post;
    bit prev_we;
    int run_len;
    logic [7:0] ra, rd;
    logic [15:0] e;
    busy_n = 0; done_n = 0; err_we = 0; err_bwe = 0;
    err_act = 0; err_addr = 0; err_hold = 0;
    err_len = 0; err_extra = 0;
    post = -1; prev_we = 1'b0; run_len = 0;
    ra = '0; rd = '0;
    @(negedge clk);
    cmd_save = save;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == inject_at) begin
        cmd_save = ~save;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      if (m_busy) busy_n++;
      if (m_done) done_n++;
      if (m_act !== m_busy) err_act++;
      if (m_act && (int'(m_addr) > maxaddr)) err_addr++;
      if (m_bwe) begin
        if (!save) err_bwe++;
        if (exp_q.size() == 0) err_extra++;
        else begin
          e = exp_q.pop_front();
          check("buf_write", 32'({m_baddr, m_bdo}), 32'(e));
        end
      end
      if (m_we) begin
        if (save) err_we++;
        if (!prev_we) begin
          if (exp_q.size() == 0) err_extra++;
          else begin
            e = exp_q.pop_front();
            check("reg_write", 32'({m_addr, m_dato}), 32'(e));
          end
          ra = m_addr;
          rd = m_dato;
          run_len = 1;
        end else begin
          run_len++;
          if (m_addr !== ra || m_dato !== rd) err_hold++;
        end
      end else if (prev_we) begin
        if (run_len != hold) err_len++;
        if (m_addr !== ra || m_dato !== rd) err_hold++;
      end
      prev_we = m_we;
      if (m_done) post = 8;
      else if (post > 0) begin
        post--;
        if (post == 0) break;
      end
      @(negedge clk);
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    int dn;
    bit found;
    rst = 1'b1;
    cmd_save = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    preload = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_ctl0", 32'({busy0, done0, act0, we0, bwe0}), 32'h0);
    check("idle_adr0", 32'({addr0, baddr0}), 32'h0);
    check("idle_dat0", 32'({dato0, bdo0}), 32'h0);
    check("idle_ctl1", 32'({busy1, done1, act1, we1, bwe1}), 32'h0);
    check("idle_adr1", 32'({addr1, baddr1, dato1, bdo1}), 32'h0);

    // SAVE with a second start mid-operation that must be ignored
    push_ops(1'b1, 128);
    run_op(1'b1, 127, 4, 300);
    check("sv_busy", 32'(busy_n), 32'(128 * 7));
    check("sv_done", 32'(done_n), 32'd1);
    check("sv_left", 32'(exp_q.size()), 32'd0);
    check("sv_extra", 32'(err_extra), 32'd0);
    check("sv_we", 32'(err_we), 32'd0);
    check("sv_act", 32'(err_act), 32'd0);
    check("sv_mem0", 32'(mem0[0]), 32'h5A);
    check("sv_mem127", 32'(mem0[127]), 32'h25);
    check("sv_end_act", 32'({busy0, act0}), 32'h0);

    // RESTORE from a preloaded buffer
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    exp_q.delete();
    push_ops(1'b0, 128);
    run_op(1'b0, 127, 4, -1);
    check("rs_busy", 32'(busy_n), 32'(128 * 8));
    check("rs_done", 32'(done_n), 32'd1);
    check("rs_left", 32'(exp_q.size()), 32'd0);
    check("rs_extra", 32'(err_extra), 32'd0);
    check("rs_bwe", 32'(err_bwe), 32'd0);
    check("rs_len", 32'(err_len), 32'd0);
    check("rs_hold", 32'(err_hold), 32'd0);
    check("rs_addr", 32'(err_addr), 32'd0);
    check("rs_act", 32'(err_act), 32'd0);
    check("rs_reg0", 32'(mreg0[0]), 32'hFF);
    check("rs_reg127", 32'(mreg0[127]), 32'h80);

    // Reset in the middle of a restore write
    exp_q.delete();
    @(negedge clk);
    cmd_save = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (we0 && addr0 == 8'd40) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reach", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async", 32'({act0, we0, busy0, done0}), 32'h0);
    check("rst_addr", 32'(addr0), 32'h0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0) dn++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done0) dn++;
    end
    check("rst_nodone", 32'(dn), 32'd0);
    push_ops(1'b1, 128);
    run_op(1'b1, 127, 4, -1);
    check("rs2_done", 32'(done_n), 32'd1);
    check("rs2_left", 32'(exp_q.size()), 32'd0);
    check("rs2_extra", 32'(err_extra), 32'd0);

    // Full 256-register SAVE with minimum hold
    sel = 1'b1;
    exp_q.delete();
    push_ops(1'b1, 256);
    run_op(1'b1, 255, 2, -1);
    check("big_busy", 32'(busy_n), 32'(256 * 5));
    check("big_done", 32'(done_n), 32'd1);
    check("big_left", 32'(exp_q.size()), 32'd0);
    check("big_extra", 32'(err_extra), 32'd0);
    check("big_we", 32'(err_we), 32'd0);
    check("big_act", 32'(err_act), 32'd0);
    check("big_end", 32'({busy1, act1, addr1}), 32'h0FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
